ftdi_tx_packetizer: RTL and testbench

- Upstream feeder for the FTDI transmit FIFO stage.
- Takes one multi-byte measurement sample per handshake and serialises it into a framed byte stream: sync, sequence, payload MSB-first, XOR checksum.
- Drives the FIFO write-enable/data interface and honours the FIFO full flag.
- Lives in the 48 MHz system clock domain.

---
 rtl/ftdi_tx_packetizer.sv | 108 ++++++++++
 tb/tb_ftdi_tx_packetizer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftdi_tx_packetizer.sv
// Frames one multi-byte sample per handshake into sync, sequence, MSB-first payload
// and XOR checksum bytes, and writes them to the FTDI transmit FIFO whenever it is not full.
module ftdi_tx_packetizer #(
  parameter int         pDataWidth   = 8,
  parameter int         pSampleBytes = 3,
  parameter logic [7:0] pSync        = 8'hA5
) (
  input  logic                        iClk,
  input  logic                        iRst,
  input  logic [8*pSampleBytes-1:0]   iSample,
  input  logic                        iSampleValid,
  output logic                        oSampleReady,
  input  logic                        iTxFull,
  output logic [pDataWidth-1:0]       oTxData,
  output logic                        oTxEn,
  output logic                        oBusy,
  output logic [7:0]                  oSeq
);

  localparam int SampleWidth = 8 * pSampleBytes;

  typedef enum logic [2:0] {
    sIdle,
    sHdr,
    sSeq,
    sData,
    sChk
  } stateT;

  stateT                  state;
  logic [SampleWidth-1:0] sampleReg;
  logic [7:0]             seqReg;
  logic [7:0]             chkReg;
  logic [2:0]             byteIdx;
  logic [7:0]             curByte;

  // Payload byte selected by the down-counting index; index pSampleBytes-1 is the MSB.
  assign curByte      = 8'(sampleReg >> {byteIdx, 3'b000});
  assign oSampleReady = (state == sIdle);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= sIdle;
      sampleReg <= '0;
      seqReg    <= '0;
      chkReg    <= '0;
      byteIdx   <= '0;
      oTxData   <= '0;
      oTxEn     <= 1'b0;
      oBusy     <= 1'b0;
      oSeq      <= '0;
    end else begin
      oTxEn <= 1'b0;
      case (state)
        sIdle: begin
          if (iSampleValid) begin
            sampleReg <= iSample;
            seqReg    <= oSeq;
            chkReg    <= oSeq;
            byteIdx   <= 3'(pSampleBytes - 1);
            oBusy     <= 1'b1;
            state     <= sHdr;
          end
        end
        sHdr: begin
          if (!iTxFull) begin
            oTxEn   <= 1'b1;
            oTxData <= pSync;
            state   <= sSeq;
          end
        end
        sSeq: begin
          if (!iTxFull) begin
            oTxEn   <= 1'b1;
            oTxData <= seqReg;
            state   <= sData;
          end
        end
        sData: begin
          if (!iTxFull) begin
            oTxEn   <= 1'b1;
            oTxData <= curByte;
            chkReg  <= chkReg ^ curByte;
            if (byteIdx == 3'd0) begin
              state <= sChk;
            end else begin
              byteIdx <= byteIdx - 3'd1;
            end
          end
        end
        sChk: begin
          if (!iTxFull) begin
            oTxEn   <= 1'b1;
            oTxData <= chkReg;
            oSeq    <= oSeq + 8'd1;
            oBusy   <= 1'b0;
            state   <= sIdle;
          end
        end
        default: begin
          oBusy <= 1'b0;
          state <= sIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ftdi_tx_packetizer.sv
// Scoreboard bench: frames expected from each accepted sample are queued by the driver
// and popped by an independent monitor on every FIFO write strobe.
`timescale 1ns/1ps
module tb_ftdi_tx_packetizer;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic [23:0] iSample = '0;
  logic        iSampleValid = 1'b0;
  logic        oSampleReady;
  logic        iTxFull;
  logic        forceFull = 1'b0;
  logic        randFull = 1'b0;
  logic        randFullEn = 1'b0;
  logic [7:0]  oTxData;
  logic        oTxEn;
  logic        oBusy;
  logic [7:0]  oSeq;

  logic [7:0]  sample1 = '0;
  logic        valid1 = 1'b0;
  logic        ready1;
  logic        full1 = 1'b0;
  logic [7:0]  txData1;
  logic        txEn1;
  logic        busy1;
  logic [7:0]  seq1;

  assign iTxFull = randFullEn ? randFull : forceFull;

  ftdi_tx_packetizer #(.pDataWidth(8), .pSampleBytes(3), .pSync(8'hA5)) dut (
    .iClk(iClk), .iRst(iRst), .iSample(iSample), .iSampleValid(iSampleValid),
    .oSampleReady(oSampleReady), .iTxFull(iTxFull), .oTxData(oTxData), .oTxEn(oTxEn),
    .oBusy(oBusy), .oSeq(oSeq)
  );

  ftdi_tx_packetizer #(.pDataWidth(8), .pSampleBytes(1), .pSync(8'hA5)) dut1 (
    .iClk(iClk), .iRst(iRst), .iSample(sample1), .iSampleValid(valid1),
    .oSampleReady(ready1), .iTxFull(full1), .oTxData(txData1), .oTxEn(txEn1),
    .oBusy(busy1), .oSeq(seq1)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [7:0] b;
    logic [1:0] kind;  // 0 sync, 1 seq, 2 payload, 3 checksum
  } expT;

  expT        sb[$];
  int         startCycles[$];
  logic [7:0] seqLog[$];
  logic [7:0] log1[$];
  int         cyc1[$];
  logic [7:0] modelSeq = 8'd0;
  int         checks = 0;
  int         passes = 0;
  int         cycle = 0;
  int         lastCycle = 0;
  int         payloadSeen = 0;
  logic       fullPrev = 1'b0;
  logic       gapCheck = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s got %0h required %0h", name, act, req);
  endtask

  always @(posedge iClk) begin
    cycle    <= cycle + 1;
    fullPrev <= iTxFull;
  end

  always @(negedge iClk) randFull <= ($urandom_range(0, 2) == 0);

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge iClk) begin
    expT e;
    if (!iRst && oTxEn) begin
      check("no_write_while_full", 32'(fullPrev), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write got %02h required no write", oTxData);
      end else begin
        e = sb.pop_front();
        check("tx_byte", 32'(oTxData), 32'(e.b));
        if (e.kind == 2'd0) startCycles.push_back(cycle);
        else if (gapCheck) check("no_gap", 32'(cycle - lastCycle), 32'd1);
        if (e.kind == 2'd1) seqLog.push_back(oTxData);
        if (e.kind == 2'd2) payloadSeen++;
        if (e.kind == 2'd3) begin
          check("ready_after_chk", 32'(oSampleReady), 32'd1);
          check("idle_after_chk", 32'(oBusy), 32'd0);
        end else begin
          check("busy_in_frame", 32'(oBusy), 32'd1);
        end
        lastCycle = cycle;
      end
    end
  end

  always @(negedge iClk) begin
    if (!iRst && txEn1) begin
      log1.push_back(txData1);
      cyc1.push_back(cycle);
    end
  end

  // Reference frame: sync, seq, payload MSB first, XOR of seq and payload.
  task automatic pushFrame(input logic [23:0] s);
    logic [7:0] c;
    logic [7:0] b;
    sb.push_back('{8'hA5, 2'd0});
    sb.push_back('{modelSeq, 2'd1});
    c = modelSeq;
    for (int k = 2; k >= 0; k--) begin
      b = s[8*k +: 8];
      c = c ^ b;
      sb.push_back('{b, 2'd2});
    end
    sb.push_back('{c, 2'd3});
    $display("accept sample %06h seq %02h chk %02h", s, modelSeq, c);
    modelSeq = modelSeq + 8'd1;
  endtask

  task automatic sendSample(input logic [23:0] s);
    int n;
    n = 0;
    iSample      = s;
    iSampleValid = 1'b1;
    while (!oSampleReady && n < 200) begin
      @(negedge iClk);
      n++;
    end
    if (oSampleReady) pushFrame(s);
    else begin
      checks++;
      $display("FAIL accept_timeout ready %0b required 1", oSampleReady);
    end
    @(negedge iClk);
    iSampleValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge iClk);
      #1;
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic resetDut();
    iRst         = 1'b1;
    iSampleValid = 1'b0;
    forceFull    = 1'b0;
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    sb.delete();
    modelSeq = 8'd0;
    @(negedge iClk);
  endtask

  task automatic waitPayload();
    int p0;
    int n;
    p0 = payloadSeen;
    n  = 0;
    while (payloadSeen == p0 && n < 100) begin
      @(negedge iClk);
      #1;
      n++;
    end
    check("payload_seen", 32'(payloadSeen > p0), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cycle %0d required finish", cycle);
    $fatal(1);
  end

  initial begin
    logic [7:0] exp1 [8];
    int n;
    exp1 = '{8'hA5, 8'h00, 8'h5A, 8'h5A, 8'hA5, 8'h01, 8'h5A, 8'h5B};

    // Reset state
    resetDut();
    check("rst_txen", 32'(oTxEn), 32'd0);
    check("rst_txdata", 32'(oTxData), 32'd0);
    check("rst_seq", 32'(oSeq), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_ready", 32'(oSampleReady), 32'd1);

    // Single frame, FIFO never full
    gapCheck = 1'b1;
    startCycles.delete();
    sendSample(24'h123456);
    drain();
    check("seq_after_one", 32'(oSeq), 32'd1);
    check("one_frame_start", 32'(startCycles.size()), 32'd1);

    // Three back-to-back samples with valid held
    resetDut();
    startCycles.delete();
    seqLog.delete();
    sendSample(24'h010203);
    sendSample(24'hFEDCBA);
    sendSample(24'h55AA00);
    drain();
    check("b2b_starts", 32'(startCycles.size()), 32'd3);
    if (startCycles.size() == 3) begin
      check("b2b_period_0", 32'(startCycles[1] - startCycles[0]), 32'd7);
      check("b2b_period_1", 32'(startCycles[2] - startCycles[1]), 32'd7);
    end
    check("b2b_seqs", 32'(seqLog.size()), 32'd3);
    if (seqLog.size() == 3) check("b2b_seq2", 32'(seqLog[2]), 32'h02);

    // Full held for five cycles right before payload byte CD
    resetDut();
    gapCheck = 1'b0;
    sendSample(24'hABCDEF);
    waitPayload();
    forceFull = 1'b1;
    repeat (5) @(negedge iClk);
    forceFull = 1'b0;
    drain();

    // Randomised samples, idle gaps and FIFO back-pressure
    randFullEn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge iClk);
      sendSample(24'($urandom));
    end
    drain();
    randFullEn = 1'b0;
    check("seq_after_random", 32'(oSeq), 32'(modelSeq));

    // Sequence wrap across 257 frames
    resetDut();
    gapCheck = 1'b1;
    seqLog.delete();
    for (int i = 0; i < 257; i++) begin
      sendSample(24'($urandom));
      if (sb.size() > 60) drain();
    end
    drain();
    check("wrap_frames", 32'(seqLog.size()), 32'd257);
    if (seqLog.size() == 257) begin
      check("wrap_seq_255", 32'(seqLog[255]), 32'hFF);
      check("wrap_seq_256", 32'(seqLog[256]), 32'h00);
    end
    check("wrap_oseq", 32'(oSeq), 32'd1);

    // Asynchronous reset while a payload byte is on the bus
    gapCheck = 1'b0;
    sendSample(24'h778899);
    waitPayload();
    #1;
    iRst = 1'b1;
    #1;
    check("midrst_txen", 32'(oTxEn), 32'd0);
    check("midrst_seq", 32'(oSeq), 32'd0);
    check("midrst_busy", 32'(oBusy), 32'd0);
    check("midrst_txdata", 32'(oTxData), 32'd0);
    sb.delete();
    modelSeq = 8'd0;
    @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
    seqLog.delete();
    gapCheck = 1'b1;
    sendSample(24'h0F1E2D);
    drain();
    check("postrst_frames", 32'(seqLog.size()), 32'd1);
    if (seqLog.size() == 1) check("postrst_seq", 32'(seqLog[0]), 32'h00);

    // Single-byte payload instance: two frames with valid held
    log1.delete();
    cyc1.delete();
    sample1 = 8'h5A;
    valid1  = 1'b1;
    n = 0;
    while (log1.size() < 8 && n < 100) begin
      @(negedge iClk);
      #1;
      n++;
    end
    valid1 = 1'b0;
    check("p1_bytes", 32'(log1.size()), 32'd8);
    if (log1.size() >= 8) begin
      for (int i = 0; i < 8; i++) check("p1_byte", 32'(log1[i]), 32'(exp1[i]));
      check("p1_period", 32'(cyc1[4] - cyc1[0]), 32'd5);
    end
    repeat (10) @(negedge iClk);

    check("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
